// File: rtl/axis_bit_spread_pkg.sv
// Shared definitions for the bit-spreading transmitter: FSM states, the
// correlator code table (also used by the receive-side correlator) and the
// log2 helper used to size counters.
package axis_bit_spread_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Longest code in the table; codes are stored right-aligned, chip k at bit k.
  localparam int MAX_CODE_LEN = 13;

  // Ceiling log2, never less than 1 so it can size a vector directly.
  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Code length per code select.
  function automatic int corr_length(input int corr_num);
    case (corr_num)
      1:       return 13;
      2:       return 7;
      default: return 11;
    endcase
  endfunction

  // Code chips per code select; a 1 bit is a +1 chip, a 0 bit is a -1 chip.
  // 0: Barker-11 + + + - - - + - - + -
  // 1: Barker-13 + + + + + - - + + - + - +
  // 2: Barker-7  + + + - - + -
  function automatic logic [MAX_CODE_LEN-1:0] corr_code(input int corr_num);
    case (corr_num)
      1:       return 13'b1010110011111;
      2:       return 13'b0000000100111;
      default: return 13'b0001001000111;
    endcase
  endfunction

endpackage

// File: rtl/axis_bit_spread_if.sv
// AXI-stream bundle shared by the word input and the chip-beat output.
interface axis_bit_spread_if #(
  parameter int DATA_W = 8
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_bit_spread_chip_mapper.sv
// Combinational beat builder: turns a held word plus the chip position of the
// beat's first lane into NUM_PARALLEL signed chips. A beat may cross one bit
// boundary; lanes at or beyond valid_cnt_i are zero.
module axis_bit_spread_chip_mapper
  import axis_bit_spread_pkg::*;
#(
  parameter int NUM_PARALLEL = 8,
  parameter int WAVE_WIDTH   = 16,
  parameter int SYMBOL_BITS  = 8,
  parameter int AMPLITUDE    = 1,
  parameter int CORR_NUM     = 0
) (
  input  logic [SYMBOL_BITS-1:0]                         word_i,
  input  logic [log2(SYMBOL_BITS+1)-1:0]                 bit_idx_i,
  input  logic [log2(corr_length(CORR_NUM))-1:0]         chip_idx_i,
  input  logic [log2(NUM_PARALLEL+1)-1:0]                valid_cnt_i,
  output logic [NUM_PARALLEL*WAVE_WIDTH-1:0]             beat_o
);

  localparam int CORR_LENGTH = corr_length(CORR_NUM);
  localparam logic [CORR_LENGTH-1:0] CODE = CORR_LENGTH'(corr_code(CORR_NUM));
  localparam logic signed [WAVE_WIDTH-1:0] CHIP_POS = WAVE_WIDTH'(AMPLITUDE);
  localparam logic signed [WAVE_WIDTH-1:0] CHIP_NEG = -CHIP_POS;

  int                     pos;
  int                     bit_sel;
  logic [SYMBOL_BITS-1:0] word_sh;
  logic [CORR_LENGTH-1:0] code_sh;

  // Map each lane to (data bit, code chip) and emit +A on agreement, -A otherwise.
  always_comb begin
    beat_o  = '0;
    pos     = 0;
    bit_sel = 0;
    word_sh = '0;
    code_sh = '0;
    for (int n = 0; n < NUM_PARALLEL; n++) begin
      pos     = int'(chip_idx_i) + n;
      bit_sel = int'(bit_idx_i);
      if (pos >= CORR_LENGTH) begin
        pos     = pos - CORR_LENGTH;
        bit_sel = bit_sel + 1;
      end
      word_sh = word_i >> bit_sel;
      code_sh = CODE >> pos;
      if (n < int'(valid_cnt_i)) begin
        beat_o[n*WAVE_WIDTH +: WAVE_WIDTH] = (word_sh[0] ~^ code_sh[0]) ? CHIP_POS : CHIP_NEG;
      end
    end
  end

endmodule

// File: rtl/axis_bit_spread.sv
// Spreading transmitter: accepts SYMBOL_BITS-wide words and emits each bit
// spread over the selected correlator code, NUM_PARALLEL signed chips per
// registered output beat. A new word may replace the final beat of the
// previous word in the same cycle, so words stream without bubbles.
module axis_bit_spread
  import axis_bit_spread_pkg::*;
#(
  parameter int NUM_PARALLEL = 8,
  parameter int MASTER_WIDTH = 128,
  parameter int SYMBOL_BITS  = 8,
  parameter int AMPLITUDE    = 1,
  parameter int CORR_NUM     = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  axis_bit_spread_if.slave   s_axis,
  axis_bit_spread_if.master  m_axis
);

  localparam int WAVE_WIDTH  = MASTER_WIDTH / NUM_PARALLEL;
  localparam int CORR_LENGTH = corr_length(CORR_NUM);
  localparam int TOTAL_CHIPS = SYMBOL_BITS * CORR_LENGTH;
  localparam int BEATS       = (TOTAL_CHIPS + NUM_PARALLEL - 1) / NUM_PARALLEL;
  localparam int LAST_CNT    = TOTAL_CHIPS - (BEATS - 1) * NUM_PARALLEL;
  localparam int FIRST_CNT   = (BEATS == 1) ? LAST_CNT : NUM_PARALLEL;
  localparam int BIT_W       = log2(SYMBOL_BITS + 1);
  localparam int CHIP_W      = log2(CORR_LENGTH);
  localparam int BEAT_W      = log2(BEATS);
  localparam int CNT_W       = log2(NUM_PARALLEL + 1);

  state_e                  state_q, state_d;
  logic [SYMBOL_BITS-1:0]  word_q, word_d;
  logic [BIT_W-1:0]        bit_idx_q, bit_idx_d;
  logic [CHIP_W-1:0]       chip_idx_q, chip_idx_d;
  logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic [MASTER_WIDTH-1:0] tdata_q, tdata_d;

  logic                    s_ready;
  logic                    s_fire;
  logic                    m_fire;

  logic [CHIP_W:0]         chip_sum;
  logic                    chip_wrap;
  logic [CHIP_W-1:0]       chip_next;
  logic [BIT_W-1:0]        bit_next;
  logic                    next_is_last;
  logic [CNT_W-1:0]        cnt_next;

  logic [SYMBOL_BITS-1:0]  map_word;
  logic [BIT_W-1:0]        map_bit;
  logic [CHIP_W-1:0]       map_chip;
  logic [CNT_W-1:0]        map_cnt;
  logic [MASTER_WIDTH-1:0] map_beat;

  // A new word is taken when idle, or when the held last beat leaves this cycle.
  assign s_ready = (state_q == ST_IDLE) | (tvalid_q & tlast_q & m_axis.tready);
  assign s_fire  = s_axis.tvalid & s_ready;
  assign m_fire  = tvalid_q & m_axis.tready;

  // Chip position of the beat following the held one; one code wrap at most.
  always_comb begin
    chip_sum     = {1'b0, chip_idx_q} + (CHIP_W+1)'(NUM_PARALLEL);
    chip_wrap    = (chip_sum >= (CHIP_W+1)'(CORR_LENGTH));
    chip_next    = chip_wrap ? CHIP_W'(chip_sum - (CHIP_W+1)'(CORR_LENGTH))
                             : chip_sum[CHIP_W-1:0];
    bit_next     = bit_idx_q + BIT_W'(chip_wrap);
    next_is_last = (beat_cnt_q == BEAT_W'(BEATS - 2));
    cnt_next     = next_is_last ? CNT_W'(LAST_CNT) : CNT_W'(NUM_PARALLEL);
  end

  // Mapper sees beat 0 of the incoming word on a load, else the next beat.
  always_comb begin
    map_word = word_q;
    map_bit  = bit_next;
    map_chip = chip_next;
    map_cnt  = cnt_next;
    if (s_fire) begin
      map_word = s_axis.tdata;
      map_bit  = '0;
      map_chip = '0;
      map_cnt  = CNT_W'(FIRST_CNT);
    end
  end

  axis_bit_spread_chip_mapper #(
    .NUM_PARALLEL (NUM_PARALLEL),
    .WAVE_WIDTH   (WAVE_WIDTH),
    .SYMBOL_BITS  (SYMBOL_BITS),
    .AMPLITUDE    (AMPLITUDE),
    .CORR_NUM     (CORR_NUM)
  ) u_chip_mapper (
    .word_i      (map_word),
    .bit_idx_i   (map_bit),
    .chip_idx_i  (map_chip),
    .valid_cnt_i (map_cnt),
    .beat_o      (map_beat)
  );

  // Next-state: load a word, retire the last beat, advance a beat, or hold on stall.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    bit_idx_d  = bit_idx_q;
    chip_idx_d = chip_idx_q;
    beat_cnt_d = beat_cnt_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tdata_d    = tdata_q;
    if (s_fire) begin
      state_d    = ST_RUN;
      word_d     = s_axis.tdata;
      bit_idx_d  = '0;
      chip_idx_d = '0;
      beat_cnt_d = '0;
      tvalid_d   = 1'b1;
      tlast_d    = (BEATS == 1);
      tdata_d    = map_beat;
    end else if (m_fire && tlast_q) begin
      state_d    = ST_IDLE;
      bit_idx_d  = '0;
      chip_idx_d = '0;
      beat_cnt_d = '0;
      tvalid_d   = 1'b0;
      tlast_d    = 1'b0;
    end else if (m_fire) begin
      bit_idx_d  = bit_next;
      chip_idx_d = chip_next;
      beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      tlast_d    = next_is_last;
      tdata_d    = map_beat;
    end
  end

  // State, counters and output register; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      bit_idx_q  <= '0;
      chip_idx_q <= '0;
      beat_cnt_q <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      bit_idx_q  <= bit_idx_d;
      chip_idx_q <= chip_idx_d;
      beat_cnt_q <= beat_cnt_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tlast  = tlast_q;

endmodule

// File: tb/tb_axis_bit_spread.sv
// Bench for axis_bit_spread: 8 lanes x 16 bits, 2-bit words, Barker-11 code.
module tb_axis_bit_spread;

  localparam logic [15:0] P = 16'h0001;
  localparam logic [15:0] N = 16'hFFFF;
  localparam logic [15:0] Z = 16'h0000;
  // Barker-11 + + + - - - + - - + -, chip k at bit k.
  localparam logic [10:0] CODE_TB = 11'b01001000111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_bit_spread_if #(.DATA_W(2))   s_if ();
  axis_bit_spread_if #(.DATA_W(128)) m_if ();

  axis_bit_spread #(
    .NUM_PARALLEL (8),
    .MASTER_WIDTH (128),
    .SYMBOL_BITS  (2),
    .AMPLITUDE    (1),
    .CORR_NUM     (0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_axis (s_if.slave),
    .m_axis (m_if.master)
  );

  assign s_if.tlast = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]   word;
    logic [1:0]   beat;
    logic         last;
    logic [127:0] data;
  } vec_t;

  vec_t vecs [6];

  int           chips_buf [24];
  logic [127:0] exp_q [$];
  logic         exp_last_q [$];
  logic [127:0] held_data;
  logic         held_last;
  logic         stalled;
  logic         accepted;
  int           sent;
  int           cycles;
  int           corr_sum;
  logic [1:0]   bb_word;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference beat from the global chip index g = beat*8 + lane.
  function automatic logic [127:0] model_beat(input logic [1:0] w, input int beat);
    logic [127:0] r;
    logic [1:0]   wsh;
    logic [10:0]  csh;
    int           g;
    r = '0;
    for (int n = 0; n < 8; n++) begin
      g = beat * 8 + n;
      if (g < 22) begin
        wsh = w >> (g / 11);
        csh = CODE_TB >> (g % 11);
        r[n*16 +: 16] = (wsh[0] == csh[0]) ? P : N;
      end
    end
    return r;
  endfunction

  // Present one word at a negedge; returns at the negedge where beat 0 is visible.
  task automatic send_word(input logic [1:0] w);
    @(negedge clk);
    s_if.tvalid = 1'b1;
    s_if.tdata  = w;
    #1;
    chk_bit("s_ready_idle", s_if.tready, 1'b1);
    @(negedge clk);
    s_if.tvalid = 1'b0;
  endtask

  // Send a word with ready high and unpack its 22 chips into chips_buf.
  task automatic collect_word(input logic [1:0] w);
    send_word(w);
    for (int b = 0; b < 3; b++) begin
      if (b > 0) @(negedge clk);
      for (int n = 0; n < 8; n++) begin
        if (b * 8 + n < 22) chips_buf[b*8+n] = int'($signed(m_if.tdata[n*16 +: 16]));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    // lanes written lane7 .. lane0
    vecs[0] = '{word: 2'b11, beat: 2'd0, last: 1'b0, data: {N,P,N,N,N,P,P,P}};
    vecs[1] = '{word: 2'b11, beat: 2'd1, last: 1'b0, data: {N,N,P,P,P,N,P,N}};
    vecs[2] = '{word: 2'b11, beat: 2'd2, last: 1'b1, data: {Z,Z,N,P,N,N,P,N}};
    vecs[3] = '{word: 2'b01, beat: 2'd0, last: 1'b0, data: {N,P,N,N,N,P,P,P}};
    vecs[4] = '{word: 2'b01, beat: 2'd1, last: 1'b0, data: {P,P,N,N,N,N,P,N}};
    vecs[5] = '{word: 2'b01, beat: 2'd2, last: 1'b1, data: {Z,Z,P,N,P,P,N,P}};

    s_if.tvalid = 1'b0;
    s_if.tdata  = 2'b00;
    m_if.tready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk_bit("rst_tvalid", m_if.tvalid, 1'b0);
    chk_bit("rst_tlast", m_if.tlast, 1'b0);
    chk_data("rst_tdata", m_if.tdata, 128'h0);
    chk_bit("rst_s_ready", s_if.tready, 1'b1);
    rst_n = 1'b1;

    // Idle with no input: nothing emitted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_bit("idle_tvalid", m_if.tvalid, 1'b0);
      chk_bit("idle_s_ready", s_if.tready, 1'b1);
    end

    // Table-driven words 2'b11 and 2'b01, ready high
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].beat == 2'd0) send_word(vecs[i].word);
      else @(negedge clk);
      chk_bit($sformatf("tbl%0d_tvalid", i), m_if.tvalid, 1'b1);
      chk_data($sformatf("tbl%0d_tdata", i), m_if.tdata, vecs[i].data);
      chk_data($sformatf("tbl%0d_model", i), m_if.tdata, model_beat(vecs[i].word, int'(vecs[i].beat)));
      chk_bit($sformatf("tbl%0d_tlast", i), m_if.tlast, vecs[i].last);
    end
    @(negedge clk);
    chk_bit("tbl_idle_after", m_if.tvalid, 1'b0);

    // Back-to-back words 2'b10 then 2'b01
    @(negedge clk);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 2'b10;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bb_word = (k < 3) ? 2'b10 : 2'b01;
      chk_bit($sformatf("b2b%0d_tvalid", k), m_if.tvalid, 1'b1);
      chk_data($sformatf("b2b%0d_tdata", k), m_if.tdata, model_beat(bb_word, k % 3));
      chk_bit($sformatf("b2b%0d_tlast", k), m_if.tlast, (k % 3) == 2);
      if (k <= 2) chk_bit($sformatf("b2b%0d_s_ready", k), s_if.tready, k == 2);
      if (k == 0) s_if.tdata = 2'b01;
      if (k == 3) s_if.tvalid = 1'b0;
    end
    @(negedge clk);
    chk_bit("b2b_idle_after", m_if.tvalid, 1'b0);

    // Reset during beat 1
    send_word(2'b11);
    @(negedge clk);
    chk_data("rstmid_beat1", m_if.tdata, model_beat(2'b11, 1));
    rst_n = 1'b0;
    #1;
    chk_bit("rstmid_tvalid", m_if.tvalid, 1'b0);
    chk_bit("rstmid_s_ready", s_if.tready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_bit("rstmid_no_resume", m_if.tvalid, 1'b0);
    send_word(2'b01);
    chk_data("rstmid_restart_b0", m_if.tdata, model_beat(2'b01, 0));
    chk_bit("rstmid_restart_last0", m_if.tlast, 1'b0);
    @(negedge clk);
    chk_data("rstmid_restart_b1", m_if.tdata, model_beat(2'b01, 1));
    @(negedge clk);
    chk_data("rstmid_restart_b2", m_if.tdata, model_beat(2'b01, 2));
    chk_bit("rstmid_restart_last2", m_if.tlast, 1'b1);
    @(negedge clk);

    // Loopback correlation: peak +/-11 at each bit, sign follows the bit
    for (int w = 1; w <= 2; w++) begin
      collect_word(2'(w));
      for (int i = 0; i < 2; i++) begin
        corr_sum = 0;
        for (int c = 0; c < 11; c++) begin
          logic [10:0] csh;
          csh = CODE_TB >> c;
          corr_sum = corr_sum + (csh[0] ? chips_buf[i*11+c] : -chips_buf[i*11+c]);
        end
        chk_int($sformatf("corr_w%0d_bit%0d", w, i), corr_sum, (((w >> i) & 1) == 1) ? 11 : -11);
      end
    end

    // Random ready over 100 random words, scoreboard plus stall stability
    sent     = 0;
    cycles   = 0;
    stalled  = 1'b0;
    accepted = 1'b0;
    s_if.tvalid = 1'b0;
    while ((sent < 100 || exp_q.size() > 0 || m_if.tvalid) && cycles < 4000) begin
      @(negedge clk);
      cycles++;
      if (stalled) begin
        chk_bit("stall_tvalid", m_if.tvalid, 1'b1);
        chk_data("stall_tdata", m_if.tdata, held_data);
        chk_bit("stall_tlast", m_if.tlast, held_last);
      end
      if (accepted) s_if.tvalid = 1'b0;
      accepted = 1'b0;
      if (!s_if.tvalid && sent < 100 && $urandom_range(0, 3) != 0) begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = 2'($urandom_range(0, 3));
      end
      m_if.tready = 1'($urandom_range(0, 1));
      #1;
      stalled = 1'b0;
      if (m_if.tvalid) begin
        if (m_if.tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rand_unexpected_beat: got %h, expected no beat", m_if.tdata);
          end else begin
            chk_data("rand_tdata", m_if.tdata, exp_q.pop_front());
            chk_bit("rand_tlast", m_if.tlast, exp_last_q.pop_front());
          end
        end else begin
          stalled   = 1'b1;
          held_data = m_if.tdata;
          held_last = m_if.tlast;
        end
      end
      if (s_if.tvalid && s_if.tready) begin
        for (int b = 0; b < 3; b++) begin
          exp_q.push_back(model_beat(s_if.tdata, b));
          exp_last_q.push_back(b == 2);
        end
        sent++;
        accepted = 1'b1;
      end
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    chk_bit("rand_done_in_budget", cycles < 4000, 1'b1);
    chk_int("rand_words_sent", sent, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
